// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave frame receiver: synchronizes sclk/mosi/ssN, shifts a 16-bit frame, publishes port/payload.
// Optional feature macro: SPI_PARITY_EN (errorData = XOR of all 16 frame bits).
module spi_frame_receiver (
  input  logic        clock,
  input  logic        reset,
  input  logic        enableSpi,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        ssN,
  output logic        loadFinish,
  output logic        errorData,
  output logic        desPort,
  output logic [13:0] dataOut,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT    = 2'd1,
    DONE     = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        sclk_meta_q, sclk_sync_q, sclk_dly_q;
  logic        mosi_meta_q, mosi_sync_q;
  logic        ssn_meta_q, ssn_sync_q;
  logic        sample_s;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  count_q, count_d;
  logic        load_finish_q, load_finish_d;
  logic        error_data_q, error_data_d;
  logic        des_port_q, des_port_d;
  logic [13:0] data_out_q, data_out_d;
  logic        busy_q, busy_d;

  function automatic logic parity16(input logic [15:0] frame);
    return ^frame;
  endfunction

  // Two-flop synchronizers; sclk gets a third flop so its rising edge can be detected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_sync_q <= 1'b0;
      sclk_dly_q  <= 1'b0;
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
      ssn_meta_q  <= 1'b1;
      ssn_sync_q  <= 1'b1;
    end else begin
      sclk_meta_q <= sclk;
      sclk_sync_q <= sclk_meta_q;
      sclk_dly_q  <= sclk_sync_q;
      mosi_meta_q <= mosi;
      mosi_sync_q <= mosi_meta_q;
      ssn_meta_q  <= ssN;
      ssn_sync_q  <= ssn_meta_q;
    end
  end

  assign sample_s = sclk_sync_q & ~sclk_dly_q;

  // FSM state, frame datapath and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      shift_q       <= 16'h0000;
      count_q       <= 5'd0;
      load_finish_q <= 1'b0;
      error_data_q  <= 1'b0;
      des_port_q    <= 1'b0;
      data_out_q    <= 14'h0000;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      count_q       <= count_d;
      load_finish_q <= load_finish_d;
      error_data_q  <= error_data_d;
      des_port_q    <= des_port_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; the published outputs load on the edge that enters DONE,
  // so they (and the loadFinish pulse) are visible exactly during DONE.
  always_comb begin
    state_d       = state_q;
    shift_d       = shift_q;
    count_d       = count_q;
    load_finish_d = 1'b0;
    error_data_d  = error_data_q;
    des_port_d    = des_port_q;
    data_out_d    = data_out_q;
    case (state_q)
      IDLE: begin
        if (enableSpi && !ssn_sync_q) begin
          state_d = SHIFT;
          count_d = 5'd0;
          shift_d = 16'h0000;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // A completed frame wins over a late deselect or disable.
        if (count_q == 5'd16) begin
          state_d       = DONE;
          load_finish_d = 1'b1;
          des_port_d    = shift_q[15];
          data_out_d    = shift_q[14:1];
`ifdef SPI_PARITY_EN
          error_data_d  = parity16(shift_q);
`else
          error_data_d  = 1'b0;
`endif
        end else if (ssn_sync_q || !enableSpi) begin
          state_d = IDLE;
        end else if (sample_s) begin
          shift_d = {shift_q[14:0], mosi_sync_q};
          count_d = count_q + 5'd1;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (ssn_sync_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_REL;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign loadFinish = load_finish_q;
  assign errorData  = error_data_q;
  assign desPort    = des_port_q;
  assign dataOut    = data_out_q;
  assign busy       = busy_q;

endmodule
